usb_ep_fifo_bank: RTL and testbench

//  Parametrised multi-endpoint data buffer for the USB endpoint core.

---
 rtl/usb_ep_fifo_bank.sv | 153 +++++++++++++++
 tb/tb_usb_ep_fifo_bank.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : usb_ep_fifo_bank
// Purpose  : NUM_EP byte-circular endpoint FIFOs between the USB byte engines
//            and a 1/2/4-byte host port, with collision and bound detection.
// Revision : 1.0
// ============================================================================
module usb_ep_fifo_bank #(
  parameter int NUM_EP = 4,
  parameter int DEPTH  = 64,
  parameter int EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [EP_W-1:0]         rx_ep,
  input  logic                    store_rx_data,
  input  logic [7:0]              rx_packet_data,
  input  logic                    flush,
  input  logic [EP_W-1:0]         tx_ep,
  input  logic                    get_tx_data,
  output logic [7:0]              tx_packet_data,
  input  logic [EP_W-1:0]         host_ep,
  input  logic                    get_rx_data,
  input  logic [1:0]              rx_size,
  output logic [31:0]             rx_data,
  input  logic                    store_tx_data,
  input  logic [1:0]              tx_size,
  input  logic [31:0]             tx_data,
  input  logic                    clear,
  output logic [NUM_EP*OCC_W-1:0] buffer_occupancy,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Size code 3 is illegal and behaves as a 4-byte access.
  logic [2:0] rx_n, tx_n;
  assign rx_n = (rx_size == 2'd0) ? 3'd1 : (rx_size == 2'd1) ? 3'd2 : 3'd4;
  assign tx_n = (tx_size == 2'd0) ? 3'd1 : (tx_size == 2'd1) ? 3'd2 : 3'd4;

  logic [NUM_EP-1:0] ovf_ep, unf_ep, hpop_ep;
  logic [31:0]       taps_ep [NUM_EP];
  logic [7:0]        head_ep [NUM_EP];

  logic [31:0] rx_data_q, rx_data_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  for (genvar e = 0; e < NUM_EP; e++) begin : g_ep
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [OCC_W-1:0] occ_q;
    logic             rx_push, tx_pop, h_push, h_pop, kill;
    logic             rx_ok, tx_ok, hpush_ok, hpop_ok;
    logic [OCC_W-1:0] n_push, n_pop;
    logic [31:0]      taps;

    always_comb begin
      rx_push  = store_rx_data && (rx_ep == EP_W'(e));
      tx_pop   = get_tx_data   && (tx_ep == EP_W'(e));
      h_push   = store_tx_data && (host_ep == EP_W'(e));
      h_pop    = get_rx_data   && (host_ep == EP_W'(e));
      kill     = (flush && (rx_ep == EP_W'(e))) || (clear && (host_ep == EP_W'(e)));
      // Byte engines win same-EP collisions; bounds use the pre-update occupancy.
      rx_ok    = rx_push && !kill && (occ_q != FULL_OCC);
      hpush_ok = h_push && !rx_push && !kill && ((FULL_OCC - occ_q) >= OCC_W'(tx_n));
      tx_ok    = tx_pop && !kill && (occ_q != '0);
      hpop_ok  = h_pop && !tx_pop && !kill && (occ_q >= OCC_W'(rx_n));
      n_push   = rx_ok ? OCC_W'(1) : (hpush_ok ? OCC_W'(tx_n) : '0);
      n_pop    = tx_ok ? OCC_W'(1) : (hpop_ok ? OCC_W'(rx_n) : '0);
      taps     = '0;
      for (int k = 0; k < 4; k++) begin
        taps[8*k +: 8] = mem_q[rd_q + PTR_W'(k)];
      end
    end

    assign ovf_ep[e]  = !kill && ((rx_push && !rx_ok) || (h_push && !hpush_ok));
    assign unf_ep[e]  = !kill && ((tx_pop && !tx_ok) || (h_pop && !hpop_ok));
    assign hpop_ep[e] = hpop_ok;
    assign taps_ep[e] = taps;
    assign head_ep[e] = (occ_q != '0) ? mem_q[rd_q] : 8'h00;
    assign buffer_occupancy[e*OCC_W +: OCC_W] = occ_q;

    always_ff @(posedge clk) begin
      if (!n_rst || kill) begin
        wr_q  <= '0;
        rd_q  <= '0;
        occ_q <= '0;
      end else begin
        wr_q  <= wr_q + n_push[PTR_W-1:0];
        rd_q  <= rd_q + n_pop[PTR_W-1:0];
        occ_q <= occ_q + n_push - n_pop;
      end
    end

    always_ff @(posedge clk) begin
      if (rx_ok) begin
        mem_q[wr_q] <= rx_packet_data;
      end else if (hpush_ok) begin
        for (int k = 0; k < 4; k++) begin
          if (3'(k) < tx_n) begin
            mem_q[wr_q + PTR_W'(k)] <= tx_data[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    overflow_d  = |ovf_ep;
    underflow_d = |unf_ep;
    for (int e = 0; e < NUM_EP; e++) begin
      if (hpop_ep[e]) begin
        case (rx_n)
          3'd1:    rx_data_d = {24'h0, taps_ep[e][7:0]};
          3'd2:    rx_data_d = {16'h0, taps_ep[e][15:0]};
          default: rx_data_d = taps_ep[e];
        endcase
      end
    end
  end

  always_comb begin
    tx_packet_data = 8'h00;
    for (int e = 0; e < NUM_EP; e++) begin
      if (tx_ep == EP_W'(e)) begin
        tx_packet_data = head_ep[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_ep_fifo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_ep_fifo_bank
// Purpose  : Scoreboard bench for usb_ep_fifo_bank against a byte-queue model.
// Revision : 1.0
// ============================================================================
module tb_usb_ep_fifo_bank;

  localparam int NUM_EP = 4;
  localparam int DEPTH  = 64;
  localparam int EP_W   = 2;
  localparam int OCC_W  = 7;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [EP_W-1:0]         rx_ep = '0, tx_ep = '0, host_ep = '0;
  logic                    store_rx_data = 1'b0, flush = 1'b0, get_tx_data = 1'b0;
  logic                    get_rx_data = 1'b0, store_tx_data = 1'b0, clear = 1'b0;
  logic [7:0]              rx_packet_data = '0;
  logic [1:0]              rx_size = '0, tx_size = '0;
  logic [31:0]             tx_data = '0;
  logic [7:0]              tx_packet_data;
  logic [31:0]             rx_data;
  logic [NUM_EP*OCC_W-1:0] buffer_occupancy;
  logic                    overflow, underflow;

  usb_ep_fifo_bank #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .rx_ep(rx_ep), .store_rx_data(store_rx_data), .rx_packet_data(rx_packet_data),
    .flush(flush), .tx_ep(tx_ep), .get_tx_data(get_tx_data), .tx_packet_data(tx_packet_data),
    .host_ep(host_ep), .get_rx_data(get_rx_data), .rx_size(rx_size), .rx_data(rx_data),
    .store_tx_data(store_tx_data), .tx_size(tx_size), .tx_data(tx_data), .clear(clear),
    .buffer_occupancy(buffer_occupancy), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        st_rx;  bit [1:0] rx_ep;  bit [7:0] rxb;  bit flush;
    bit        get_tx; bit [1:0] tx_ep;
    bit [1:0]  host_ep; bit get_rx; bit [1:0] rx_size;
    bit        st_tx;  bit [1:0] tx_size; bit [31:0] txd; bit clear;
  } op_t;

  typedef struct {
    bit [31:0] rxd; bit ov; bit un; bit [NUM_EP*OCC_W-1:0] occ; bit [7:0] head;
  } exp_t;

  exp_t exp_q[$];
  byte unsigned mq[NUM_EP][$];
  bit [31:0] m_rxd;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int nbytes(input bit [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic op_t nop();
    op_t o = '{default: 0};
    return o;
  endfunction

  function automatic exp_t snapshot(input bit ov, input bit un, input bit [1:0] tep);
    exp_t r;
    r.rxd = m_rxd; r.ov = ov; r.un = un;
    r.occ = '0;
    for (int e = 0; e < NUM_EP; e++) r.occ[e*OCC_W +: OCC_W] = OCC_W'(mq[e].size());
    r.head = (mq[tep].size() > 0) ? mq[tep][0] : 8'h00;
    return r;
  endfunction

  // One clock of stimulus; the model decides every acceptance from the
  // occupancies seen at the start of the cycle, then applies all effects.
  task automatic step(input op_t o);
    int  sz[NUM_EP];
    int  n, nt;
    bit  ov, un;
    @(negedge clk);
    store_rx_data = o.st_rx; rx_ep = o.rx_ep; rx_packet_data = o.rxb; flush = o.flush;
    get_tx_data = o.get_tx; tx_ep = o.tx_ep; host_ep = o.host_ep; get_rx_data = o.get_rx;
    rx_size = o.rx_size; store_tx_data = o.st_tx; tx_size = o.tx_size; tx_data = o.txd;
    clear = o.clear;
    n = nbytes(o.rx_size); nt = nbytes(o.tx_size);
    ov = 0; un = 0;
    for (int e = 0; e < NUM_EP; e++) sz[e] = mq[e].size();
    for (int e = 0; e < NUM_EP; e++) begin
      bit rxp, hpu, txp, hpo;
      rxp = o.st_rx  && (o.rx_ep == e);
      txp = o.get_tx && (o.tx_ep == e);
      hpu = o.st_tx  && (o.host_ep == e);
      hpo = o.get_rx && (o.host_ep == e);
      if ((o.flush && o.rx_ep == e) || (o.clear && o.host_ep == e)) begin
        mq[e].delete();
        continue;
      end
      if (txp) begin
        if (sz[e] >= 1) void'(mq[e].pop_front()); else un = 1;
        if (hpo) un = 1;
      end else if (hpo) begin
        if (sz[e] >= n) begin
          m_rxd = 0;
          for (int k = 0; k < n; k++) m_rxd[8*k +: 8] = mq[e].pop_front();
        end else un = 1;
      end
      if (rxp) begin
        if (sz[e] < DEPTH) mq[e].push_back(o.rxb); else ov = 1;
        if (hpu) ov = 1;
      end else if (hpu) begin
        if (DEPTH - sz[e] >= nt) begin
          for (int k = 0; k < nt; k++) mq[e].push_back(o.txd[8*k +: 8]);
        end else ov = 1;
      end
    end
    exp_q.push_back(snapshot(ov, un, o.tx_ep));
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    n_rst = 1'b0;
    store_rx_data = 0; flush = 0; get_tx_data = 0; get_rx_data = 0; store_tx_data = 0;
    clear = 0; tx_ep = '0;
    for (int e = 0; e < NUM_EP; e++) mq[e].delete();
    m_rxd = '0;
    exp_q.push_back(snapshot(1'b0, 1'b0, 2'd0));
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("rx_data",   64'(rx_data),          64'(r.rxd));
        chk("overflow",  64'(overflow),         64'(r.ov));
        chk("underflow", 64'(underflow),        64'(r.un));
        chk("occupancy", 64'(buffer_occupancy), 64'(r.occ));
        chk("tx_head",   64'(tx_packet_data),   64'(r.head));
      end
    end
  end

  initial begin
    op_t o;
    int  guard;
    // reset
    reset_cycle(); reset_cycle();
    @(negedge clk); n_rst = 1'b1;
    // width mix on EP1
    o = nop(); o.st_tx = 1; o.host_ep = 1; o.tx_size = 2; o.txd = 32'hDDCCBBAA; o.tx_ep = 1; step(o);
    o = nop(); o.get_tx = 1; o.tx_ep = 1; step(o); step(o);
    o = nop(); o.tx_ep = 1; step(o);
    // pointer wrap on EP0
    o = nop(); o.flush = 1; o.rx_ep = 0; step(o);
    for (int i = 0; i < 62; i++) begin o = nop(); o.st_rx = 1; o.rx_ep = 0; o.rxb = 8'(i + 16); step(o); end
    for (int i = 0; i < 60; i++) begin o = nop(); o.get_rx = 1; o.host_ep = 0; step(o); end
    o = nop(); o.st_tx = 1; o.host_ep = 0; o.tx_size = 2; o.txd = 32'h04030201; step(o);
    o = nop(); o.get_rx = 1; o.host_ep = 0; o.rx_size = 1; step(o);
    o = nop(); o.get_rx = 1; o.host_ep = 0; o.rx_size = 2; step(o);
    // full / empty bounds
    for (int i = 0; i < 16; i++) begin
      o = nop(); o.st_tx = 1; o.host_ep = 2; o.tx_size = 3; o.txd = $urandom; o.tx_ep = 2; step(o);
    end
    o = nop(); o.st_rx = 1; o.rx_ep = 2; o.rxb = 8'h5A; o.tx_ep = 2; step(o);
    o = nop(); o.st_tx = 1; o.host_ep = 2; o.tx_size = 0; step(o);
    o = nop(); o.clear = 1; o.host_ep = 3; step(o);
    o = nop(); o.get_rx = 1; o.host_ep = 3; o.rx_size = 1; step(o);
    o = nop(); o.get_tx = 1; o.tx_ep = 3; step(o);
    // same-EP collisions on EP0 with 5 bytes
    o = nop(); o.flush = 1; o.rx_ep = 0; step(o);
    for (int i = 0; i < 5; i++) begin o = nop(); o.st_rx = 1; o.rx_ep = 0; o.rxb = 8'(i + 8'hA0); step(o); end
    o = nop(); o.st_rx = 1; o.rx_ep = 0; o.rxb = 8'hEE; o.st_tx = 1; o.host_ep = 0; o.txd = 32'h77; step(o);
    o = nop(); o.get_tx = 1; o.tx_ep = 0; o.get_rx = 1; o.host_ep = 0; step(o);
    // full FIFO rejects push despite concurrent pop; empty rejects pop despite push
    o = nop(); o.st_rx = 1; o.rx_ep = 2; o.get_tx = 1; o.tx_ep = 2; step(o);
    o = nop(); o.st_rx = 1; o.rx_ep = 3; o.get_rx = 1; o.host_ep = 3; o.tx_ep = 3; step(o);
    // flush mid-operation on EP1
    o = nop(); o.clear = 1; o.host_ep = 1; step(o);
    for (int i = 0; i < 5; i++) begin
      o = nop(); o.st_tx = 1; o.host_ep = 1; o.tx_size = 1; o.txd = $urandom; step(o);
    end
    o = nop(); o.flush = 1; o.rx_ep = 1; o.st_rx = 1; o.rxb = 8'h99; o.get_rx = 1; o.host_ep = 1;
    o.tx_ep = 0; step(o);
    o = nop(); step(o);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      o = nop();
      o.st_rx   = ($urandom_range(0, 99) < 40);
      o.rx_ep   = 2'($urandom_range(0, 3));
      o.rxb     = 8'($urandom);
      o.flush   = ($urandom_range(0, 99) < 2);
      o.get_tx  = ($urandom_range(0, 99) < 40);
      o.tx_ep   = 2'($urandom_range(0, 3));
      o.host_ep = 2'($urandom_range(0, 3));
      o.get_rx  = ($urandom_range(0, 99) < 25);
      o.rx_size = 2'($urandom_range(0, 3));
      o.st_tx   = ($urandom_range(0, 99) < 25);
      o.tx_size = 2'($urandom_range(0, 3));
      o.txd     = $urandom;
      o.clear   = ($urandom_range(0, 99) < 2);
      step(o);
    end
    o = nop(); step(o);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
